// File: rtl/complex_divider_if.sv
// Handshake and data bundle for the complex divider.
//   master: drives operands/in_valid and out_ready (upstream/downstream side)
//   slave : the divider; drives in_ready, results, out_valid and flags
interface complex_divider_if #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_WIDTH = DATA_WIDTH
);
  logic                           in_valid;
  logic                           in_ready;
  logic signed [DATA_WIDTH-1:0]   real_a;
  logic signed [DATA_WIDTH-1:0]   imag_a;
  logic signed [DATA_WIDTH-1:0]   real_b;
  logic signed [DATA_WIDTH-1:0]   imag_b;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUTPUT_WIDTH-1:0] real_result;
  logic signed [OUTPUT_WIDTH-1:0] imag_result;
  logic                           div_by_zero;
  logic                           saturated;

  modport master (
    output in_valid, real_a, imag_a, real_b, imag_b, out_ready,
    input  in_ready, out_valid, real_result, imag_result, div_by_zero, saturated
  );

  modport slave (
    input  in_valid, real_a, imag_a, real_b, imag_b, out_ready,
    output in_ready, out_valid, real_result, imag_result, div_by_zero, saturated
  );
endinterface

// File: rtl/complex_divider.sv
// Sequential fixed-point complex divider: (real_a + j imag_a) / (real_b + j imag_b).
// Used as per-subcarrier equalizer (received symbol / channel estimate).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): in_valid/in_ready + four signed operands;
//                out_valid/out_ready + real/imag result, div_by_zero, saturated
// One operation in flight; result appears OUTPUT_WIDTH+2 edges after accept.
module complex_divider #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH_F = 14,
  parameter int unsigned DATA_WIDTH_I = 1,
  parameter int unsigned OUTPUT_WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  complex_divider_if.slave bus
);

  // Product/sum width: two 2W-bit products summed plus sign headroom.
  localparam int unsigned PW  = 2 * DATA_WIDTH + 2;
  localparam int unsigned DNW = 2 * DATA_WIDTH + 1;
  localparam int unsigned QW  = OUTPUT_WIDTH - 1;
  // Dividend |num|<<F compared with den<<QW; wide enough for both.
  localparam int unsigned NW  = PW + DATA_WIDTH_F + OUTPUT_WIDTH;
  localparam int unsigned CW  = $clog2(OUTPUT_WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Format sanity: sign + integer + fraction bits must fit the word.
  if (DATA_WIDTH_F + DATA_WIDTH_I + 1 > DATA_WIDTH) begin : g_bad_format
    $error("complex_divider: DATA_WIDTH_F + DATA_WIDTH_I + 1 exceeds DATA_WIDTH");
  end

  logic [2:0] state;
  logic [2:0] state_next;

  logic signed [DATA_WIDTH-1:0] ar, ai, br, bi;
  logic signed [PW-1:0]         num_re, num_im;
  logic [DNW-1:0]               den;
  logic                         neg_re, neg_im, sat_re, sat_im, dz;
  logic [NW-1:0]                rem_re, rem_im, dvs;
  logic [QW-1:0]                q_re, q_im;
  logic [CW-1:0]                cnt;

  logic                           in_ready_q, out_valid_q, div_by_zero_q, saturated_q;
  logic signed [OUTPUT_WIDTH-1:0] real_result_q, imag_result_q;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.real_result = real_result_q;
  assign bus.imag_result = imag_result_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.saturated   = saturated_q;

  // Sign-extended operands so products and sums are exact.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = PW'(ar);
  assign ai_x = PW'(ai);
  assign br_x = PW'(br);
  assign bi_x = PW'(bi);

  // Magnitudes, scaled dividends and overflow threshold for the load step.
  logic [PW-1:0] mag_re_c, mag_im_c;
  logic [NW-1:0] n_re_c, n_im_c, limit_c;
  logic          ge_re_c, ge_im_c;

  always_comb begin
    mag_re_c = num_re[PW-1] ? -num_re : num_re;
    mag_im_c = num_im[PW-1] ? -num_im : num_im;
    n_re_c   = NW'(mag_re_c) << DATA_WIDTH_F;
    n_im_c   = NW'(mag_im_c) << DATA_WIDTH_F;
    limit_c  = NW'(den) << QW;
    ge_re_c  = rem_re >= dvs;
    ge_im_c  = rem_im >= dvs;
  end

  // Apply saturation and sign to an unsigned quotient magnitude.
  function automatic logic signed [OUTPUT_WIDTH-1:0] apply_sign(
    input logic [QW-1:0] q, input logic neg, input logic sat, input logic zero);
    logic [QW-1:0] mag;
    mag = sat ? '1 : q;
    if (zero) return '0;
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.in_valid && in_ready_q) state_next = S_PREP;
      S_PREP: state_next = S_LOAD;
      S_LOAD: state_next = S_DIV;
      S_DIV:  if (cnt == CW'(QW - 1)) state_next = S_DONE;
      S_DONE: if (out_valid_q && bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= '0; ai <= '0; br <= '0; bi <= '0;
      num_re <= '0; num_im <= '0; den <= '0;
      neg_re <= 1'b0; neg_im <= 1'b0; sat_re <= 1'b0; sat_im <= 1'b0; dz <= 1'b0;
      rem_re <= '0; rem_im <= '0; dvs <= '0;
      q_re <= '0; q_im <= '0; cnt <= '0;
      in_ready_q <= 1'b1; out_valid_q <= 1'b0;
      real_result_q <= '0; imag_result_q <= '0;
      div_by_zero_q <= 1'b0; saturated_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            ar <= bus.real_a;
            ai <= bus.imag_a;
            br <= bus.real_b;
            bi <= bus.imag_b;
            in_ready_q <= 1'b0;
          end
        end
        S_PREP: begin
          num_re <= ar_x * br_x + ai_x * bi_x;
          num_im <= ai_x * br_x - ar_x * bi_x;
          den    <= DNW'(br_x * br_x + bi_x * bi_x);
        end
        S_LOAD: begin
          // Quotient needs more than QW bits exactly when |num|<<F >= den<<QW.
          neg_re <= num_re[PW-1];
          neg_im <= num_im[PW-1];
          sat_re <= n_re_c >= limit_c;
          sat_im <= n_im_c >= limit_c;
          dz     <= den == '0;
          rem_re <= n_re_c;
          rem_im <= n_im_c;
          dvs    <= NW'(den) << (QW - 1);
          cnt    <= '0;
        end
        S_DIV: begin
          // Restoring step, MSB first, shared shifted divisor.
          rem_re <= ge_re_c ? rem_re - dvs : rem_re;
          rem_im <= ge_im_c ? rem_im - dvs : rem_im;
          q_re   <= {q_re[QW-2:0], ge_re_c};
          q_im   <= {q_im[QW-2:0], ge_im_c};
          dvs    <= dvs >> 1;
          cnt    <= cnt + CW'(1);
        end
        S_DONE: begin
          if (!out_valid_q) begin
            real_result_q <= apply_sign(q_re, neg_re, sat_re, dz);
            imag_result_q <= apply_sign(q_im, neg_im, sat_im, dz);
            div_by_zero_q <= dz;
            saturated_q   <= !dz && (sat_re || sat_im);
            out_valid_q   <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Directed self-checking bench for complex_divider (plus a short random sweep
// against an exact integer reference).
module tb_complex_divider;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  complex_divider_if #(.DATA_WIDTH(W), .OUTPUT_WIDTH(W)) bus ();

  complex_divider #(
    .DATA_WIDTH(W), .DATA_WIDTH_F(14), .DATA_WIDTH_I(1), .OUTPUT_WIDTH(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Issue one operation and wait for out_valid; lat = edges after accept, -1 on timeout.
  task automatic run_op(input logic signed [W-1:0] ar, ai, br, bi, input bit release_now,
                        output logic signed [W-1:0] re, im, output logic dz, sat,
                        output int lat);
    int waited;
    lat = -1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    bus.real_a = ar; bus.imag_a = ai; bus.real_b = br; bus.imag_b = bi;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    re = bus.real_result; im = bus.imag_result;
    dz = bus.div_by_zero; sat = bus.saturated;
    if (release_now) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.real_result !== '0 ||
        bus.imag_result !== '0 || bus.div_by_zero !== 1'b0 || bus.saturated !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b re=%0d im=%0d dz=%b sat=%b (need 1 0 0 0 0 0)",
               bus.in_ready, bus.out_valid, bus.real_result, bus.imag_result,
               bus.div_by_zero, bus.saturated);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b (need 1 0)", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    logic signed [W-1:0] re, im;
    logic dz, sat;
    int lat;
    // (16384,0)/(0,16384) = 1/j = -j
    run_op(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd0 || im !== -16'sd16384 || sat !== 1'b0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL div_by_j: got (%0d,%0d) sat=%b dz=%b need (0,-16384) 0 0", re, im, sat, dz);
    end
    checks++;
    if (lat !== 18) begin
      failures++;
      $display("FAIL latency_div_by_j: got %0d need 18", lat);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_state: out_valid=%b in_ready=%b need 0 1", bus.out_valid, bus.in_ready);
    end
    run_op(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd16384 || im !== 16'sd0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL equal_operands: got (%0d,%0d) sat=%b need (16384,0) 0", re, im, sat);
    end
    // 16384*16384/24576 = 10922.67 truncates to 10922
    run_op(16'sd16384, 16'sd0, 16'sd24576, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd10922 || im !== 16'sd0) begin
      failures++;
      $display("FAIL trunc_pos: got (%0d,%0d) need (10922,0)", re, im);
    end
    // Truncation toward zero on the negative side
    run_op(-16'sd16384, 16'sd0, 16'sd24576, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== -16'sd10922 || im !== 16'sd0) begin
      failures++;
      $display("FAIL trunc_neg: got (%0d,%0d) need (-10922,0)", re, im);
    end
    // (-16384+j8192)/16384 = (-16384, 8192)
    run_op(-16'sd16384, 16'sd8192, 16'sd16384, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== -16'sd16384 || im !== 16'sd8192) begin
      failures++;
      $display("FAIL mixed_sign: got (%0d,%0d) need (-16384,8192)", re, im);
    end
  endtask

  task automatic test_extremes();
    logic signed [W-1:0] re, im;
    logic dz, sat;
    int lat;
    // num_re = 2^31, den = 2^31 -> 1.0
    run_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd16384 || im !== 16'sd0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL most_negative_all: got (%0d,%0d) sat=%b need (16384,0) 0", re, im, sat);
    end
    // 16384 / -32768 = -0.5
    run_op(16'sd16384, 16'sd0, -16'sd32768, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== -16'sd8192 || im !== 16'sd0) begin
      failures++;
      $display("FAIL most_negative_den: got (%0d,%0d) need (-8192,0)", re, im);
    end
  endtask

  task automatic test_saturation();
    logic signed [W-1:0] re, im;
    logic dz, sat;
    int lat;
    run_op(16'sd16384, 16'sd0, 16'sd8192, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd32767 || im !== 16'sd0 || sat !== 1'b1 || dz !== 1'b0) begin
      failures++;
      $display("FAIL sat_pos: got (%0d,%0d) sat=%b dz=%b need (32767,0) 1 0", re, im, sat, dz);
    end
    run_op(-16'sd16384, 16'sd0, 16'sd8192, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== -16'sd32767 || im !== 16'sd0 || sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: got (%0d,%0d) sat=%b need (-32767,0) 1", re, im, sat);
    end
  endtask

  task automatic test_div_by_zero();
    logic signed [W-1:0] re, im;
    logic dz, sat;
    int lat;
    run_op(16'sd1000, -16'sd2000, 16'sd0, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd0 || im !== 16'sd0 || dz !== 1'b1 || sat !== 1'b0) begin
      failures++;
      $display("FAIL div_by_zero: got (%0d,%0d) dz=%b sat=%b need (0,0) 1 0", re, im, dz, sat);
    end
    checks++;
    if (lat !== 18) begin
      failures++;
      $display("FAIL latency_div_by_zero: got %0d need 18", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] re, im;
    logic dz, sat;
    int lat;
    run_op(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b0, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd0 || im !== -16'sd16384 || lat !== 18) begin
      failures++;
      $display("FAIL hold_first: got (%0d,%0d) lat=%0d need (0,-16384) 18", re, im, lat);
    end
    // Stall for 10 cycles with busy-time in_valid pulses
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.real_a = 16'sd100; bus.imag_a = 16'sd200; bus.real_b = 16'sd300; bus.imag_b = 16'sd400;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.real_result !== 16'sd0 ||
          bus.imag_result !== -16'sd16384 || bus.saturated !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: ov=%b ir=%b (%0d,%0d) need 1 0 (0,-16384)",
                 i, bus.out_valid, bus.in_ready, bus.real_result, bus.imag_result);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_after_stall: out_valid=%b in_ready=%b need 0 1", bus.out_valid, bus.in_ready);
    end
    // Immediate follow-on op, accepted on the very next edge
    run_op(16'sd8192, 16'sd0, 16'sd16384, 16'sd0, 1'b1, re, im, dz, sat, lat);
    checks++;
    if (re !== 16'sd8192 || im !== 16'sd0 || lat !== 18) begin
      failures++;
      $display("FAIL back_to_back: got (%0d,%0d) lat=%0d need (8192,0) 18", re, im, lat);
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    @(negedge clk);
    bus.real_a = 16'sd4096; bus.imag_a = 16'sd0; bus.real_b = 16'sd8192; bus.imag_b = 16'sd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_div: out_valid=%b in_ready=%b need 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL stale_result: out_valid seen=%b need 0", seen);
    end
  endtask

  // Exact integer reference for one component.
  function automatic void ref_comp(input longint num, input longint den,
                                   output logic signed [W-1:0] r, output bit sat);
    longint mag, q;
    sat = 1'b0;
    mag = (num < 0) ? -num : num;
    q = (mag * 64'sd16384) / den;
    if (q > 32767) begin
      q = 32767;
      sat = 1'b1;
    end
    r = (num < 0) ? W'(-q) : W'(q);
  endfunction

  task automatic test_random();
    logic signed [W-1:0] ar, ai, br, bi, re, im, ere, eim;
    logic dz, sat;
    bit sre, sim, esat, edz;
    longint nre, nim, den;
    int lat;
    for (int n = 0; n < 300; n++) begin
      ar = W'($urandom); ai = W'($urandom);
      if (n % 3 == 0) begin
        br = W'($urandom_range(0, 600)) - 16'sd300;
        bi = W'($urandom_range(0, 600)) - 16'sd300;
      end else begin
        br = W'($urandom); bi = W'($urandom);
      end
      nre = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
      nim = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
      den = longint'(br) * longint'(br) + longint'(bi) * longint'(bi);
      if (den == 0) begin
        ere = '0; eim = '0; esat = 1'b0; edz = 1'b1;
      end else begin
        ref_comp(nre, den, ere, sre);
        ref_comp(nim, den, eim, sim);
        esat = sre | sim; edz = 1'b0;
      end
      run_op(ar, ai, br, bi, 1'b1, re, im, dz, sat, lat);
      checks++;
      if (re !== ere || im !== eim || dz !== edz || sat !== esat || lat !== 18) begin
        failures++;
        $display("FAIL random[%0d]: a=(%0d,%0d) b=(%0d,%0d) got (%0d,%0d) dz=%b sat=%b lat=%0d need (%0d,%0d) dz=%b sat=%b lat=18",
                 n, ar, ai, br, bi, re, im, dz, sat, lat, ere, eim, edz, esat);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.real_a = '0; bus.imag_a = '0; bus.real_b = '0; bus.imag_b = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_saturation();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_div();
    test_basic();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
